// File: rtl/reg_wb_sequencer.sv
// Writeback sequencer: queues ALU/load results in a small FIFO and emits one registered
// write per cycle (branch pc updates take priority) as a select code + data for the bank demux.
module reg_wb_sequencer #(
    parameter int PA_DATA  = 32,
    parameter int PA_SEL   = 9,
    parameter int PA_DEPTH = 4,
    parameter int PA_PTR   = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                alu_valid,
    input  logic [3:0]          alu_rd,
    input  logic [PA_DATA-1:0]  alu_data,
    output logic                alu_ready,
    input  logic                ld_valid,
    input  logic [3:0]          ld_rd,
    input  logic [PA_DATA-1:0]  ld_data,
    output logic                ld_ready,
    input  logic                br_valid,
    input  logic [PA_DATA-1:0]  br_target,
    output logic                wb_valid,
    output logic [PA_SEL-1:0]   wb_sel,
    output logic [PA_DATA-1:0]  wb_data,
    output logic [PA_PTR:0]     fifo_count
);

    localparam logic [PA_PTR:0]   LP_DEPTH    = (PA_PTR+1)'(PA_DEPTH);
    localparam logic [PA_SEL-1:0] LP_SEL_PC   = PA_SEL'(255);
    localparam logic [PA_SEL-1:0] LP_SEL_IDLE = '1;

    logic [3:0]         r_mem_rd   [PA_DEPTH];
    logic [PA_DATA-1:0] r_mem_data [PA_DEPTH];
    logic [PA_PTR-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PA_PTR:0]    r_count;
    logic               r_wb_valid;
    logic [PA_SEL-1:0]  r_wb_sel;
    logic [PA_DATA-1:0] r_wb_data;

    logic [PA_PTR:0]    w_space;
    logic [PA_PTR:0]    w_push_cnt;
    logic [PA_PTR-1:0]  w_ld_idx;
    logic               w_alu_push, w_ld_push, w_pop;
    logic               w_wb_valid;
    logic [PA_SEL-1:0]  w_wb_sel;
    logic [PA_DATA-1:0] w_wb_data;

    // Readies look only at the registered count, so a same-cycle pop never creates space.
    assign w_space    = LP_DEPTH - r_count;
    assign alu_ready  = (w_space != '0);
    assign w_alu_push = alu_valid & alu_ready;
    assign ld_ready   = (w_space >= ((PA_PTR+1)'(1) + (PA_PTR+1)'(w_alu_push)));
    assign w_ld_push  = ld_valid & ld_ready;
    assign w_pop      = ~br_valid & (r_count != '0);
    assign w_push_cnt = (PA_PTR+1)'(w_alu_push) + (PA_PTR+1)'(w_ld_push);
    assign w_ld_idx   = r_wr_ptr + PA_PTR'(w_alu_push);

    // NOTE: storage array has no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_mem_rd[r_wr_ptr]   <= alu_rd;
            r_mem_data[r_wr_ptr] <= alu_data;
        end
        if (w_ld_push) begin
            r_mem_rd[w_ld_idx]   <= ld_rd;
            r_mem_data[w_ld_idx] <= ld_data;
        end
    end

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        w_wb_valid = 1'b0;
        w_wb_sel   = LP_SEL_IDLE;
        w_wb_data  = '0;
        if (br_valid) begin
            w_wb_valid = 1'b1;
            w_wb_sel   = LP_SEL_PC;
            w_wb_data  = br_target;
        end else if (w_pop) begin
            w_wb_valid = 1'b1;
            w_wb_sel   = {{(PA_SEL-4){1'b0}}, r_mem_rd[r_rd_ptr]};
            w_wb_data  = r_mem_data[r_rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_sel   <= LP_SEL_IDLE;
            r_wb_data  <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + w_push_cnt[PA_PTR-1:0];
            r_rd_ptr   <= r_rd_ptr + PA_PTR'(w_pop);
            r_count    <= r_count + w_push_cnt - (PA_PTR+1)'(w_pop);
            r_wb_valid <= w_wb_valid;
            r_wb_sel   <= w_wb_sel;
            r_wb_data  <= w_wb_data;
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_sel     = r_wb_sel;
    assign wb_data    = r_wb_data;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Bench for reg_wb_sequencer: directed scenarios then random traffic, all checked against a
// queue-based model of the writeback rules.
module tb_reg_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        alu_valid, ld_valid, br_valid;
    logic [3:0]  alu_rd, ld_rd;
    logic [31:0] alu_data, ld_data, br_target;
    logic        alu_ready, ld_ready, wb_valid;
    logic [8:0]  wb_sel;
    logic [31:0] wb_data;
    logic [2:0]  fifo_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [35:0] q[$];
    logic        exp_valid;
    logic [8:0]  exp_sel;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    reg_wb_sequencer dut (
        .clk(clk), .rst_b(rst_b),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .br_valid(br_valid), .br_target(br_target),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                          input logic lv, input logic [3:0] lr, input logic [31:0] ldd,
                          input logic bv, input logic [31:0] bt);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
        br_valid  = bv; br_target = bt;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check readies against free space, then advance the model across the edge.
    task automatic step();
        int          space;
        logic        a_acc, l_acc;
        logic [35:0] e;
        #1;
        space = 4 - q.size();
        a_acc = alu_valid && (space >= 1);
        l_acc = ld_valid && (space >= 1 + (a_acc ? 1 : 0));
        chk("alu_ready", alu_ready, space >= 1);
        chk("ld_ready", ld_ready, space >= 1 + ((alu_valid && space >= 1) ? 1 : 0));
        @(posedge clk);
        if (br_valid) begin
            exp_valid = 1'b1; exp_sel = 9'h0FF; exp_data = br_target;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            exp_valid = 1'b1; exp_sel = {5'b0, e[35:32]}; exp_data = e[31:0];
        end else begin
            exp_valid = 1'b0; exp_sel = 9'h1FF; exp_data = 32'h0;
        end
        if (a_acc) q.push_back({alu_rd, alu_data});
        if (l_acc) q.push_back({ld_rd, ld_data});
        #1;
        chk("wb_valid", wb_valid, exp_valid);
        chk("wb_sel", wb_sel, exp_sel);
        chk("wb_data", wb_data, exp_data);
        chk("fifo_count", fifo_count, q.size());
    endtask

    initial begin
        rst_b = 1'b1;
        idle_in();
        #12;
        chk("rst_valid", wb_valid, 0);
        chk("rst_sel", wb_sel, 9'h1FF);
        chk("rst_data", wb_data, 0);
        chk("rst_count", fifo_count, 0);
        rst_b = 1'b0;
        @(posedge clk); #1;

        // Single ALU write: visible one edge after the push, then idle.
        set_in(1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step();
        chk("single_count", fifo_count, 1);
        idle_in();
        step();
        chk("single_sel", wb_sel, 9'h005);
        chk("single_data", wb_data, 32'hDEADBEEF);
        step();
        chk("single_idle", wb_sel, 9'h1FF);

        // Dual push to the same rd: ALU value first, load value last.
        set_in(1, 4'd3, 32'h11, 1, 4'd3, 32'h22, 0, 0);
        step();
        chk("dual_count2", fifo_count, 2);
        idle_in();
        step();
        chk("dual_first", wb_data, 32'h11);
        chk("dual_count1", fifo_count, 1);
        step();
        chk("dual_second", wb_data, 32'h22);
        chk("dual_count0", fifo_count, 0);

        // Branch preemption over two queued entries.
        set_in(1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 32'h100);
        step();
        chk("br1_sel", wb_sel, 9'h0FF);
        chk("br1_count", fifo_count, 2);
        step();
        chk("br2_data", wb_data, 32'h100);
        chk("br2_count", fifo_count, 2);
        idle_in();
        step();
        chk("after_br_a", wb_sel, 9'h001);
        step();
        chk("after_br_b", wb_data, 32'hA2);

        // Fill to full under a branch burst, then check backpressure and recovery.
        for (int i = 0; i < 4; i++) begin
            set_in(1, 4'(i + 6), 32'h300 + 32'(i), 0, 0, 0, 1, 32'h200);
            step();
        end
        chk("full_count", fifo_count, 4);
        set_in(1, 4'd9, 32'h999, 1, 4'd9, 32'h998, 1, 32'h204);
        #1;
        chk("full_alu_ready", alu_ready, 0);
        chk("full_ld_ready", ld_ready, 0);
        step();
        chk("full_hold", fifo_count, 4);
        set_in(1, 4'd9, 32'h999, 0, 0, 0, 0, 0);
        #1;
        chk("full_pop_alu_ready", alu_ready, 0);
        step();
        chk("full_pop_count", fifo_count, 3);
        chk("recover_alu_ready", alu_ready, 1);

        // ld_ready gating with one slot left.
        set_in(1, 4'd10, 32'hAAA, 1, 4'd11, 32'hBBB, 1, 32'h208);
        #1;
        chk("gate_alu_ready", alu_ready, 1);
        chk("gate_ld_ready", ld_ready, 0);
        step();
        chk("gate_count", fifo_count, 4);
        idle_in();
        repeat (5) step();

        // Asynchronous reset in the middle of a cycle with three entries queued.
        set_in(1, 4'd12, 32'hC0, 1, 4'd13, 32'hC1, 1, 32'h400);
        step();
        set_in(1, 4'd14, 32'hC2, 0, 0, 0, 1, 32'h404);
        step();
        chk("pre_rst_count", fifo_count, 3);
        idle_in();
        #2 rst_b = 1'b1;
        #1;
        chk("async_valid", wb_valid, 0);
        chk("async_sel", wb_sel, 9'h1FF);
        chk("async_data", wb_data, 0);
        chk("async_count", fifo_count, 0);
        q.delete();
        #5 rst_b = 1'b0;
        @(posedge clk); #1;
        repeat (3) step();
        chk("post_rst_idle", wb_sel, 9'h1FF);

        // Random traffic against the model.
        repeat (400) begin
            set_in($urandom_range(0, 9) < 6, 4'($urandom), $urandom,
                   $urandom_range(0, 9) < 5, 4'($urandom), $urandom,
                   $urandom_range(0, 3) == 0, $urandom);
            step();
        end
        idle_in();
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wb_sequencer.md
Name: reg_wb_sequencer

Overview:
- Writeback sequencer directly upstream of the 17-way register-bank demux.
- Collects register results from the ALU and load unit in a small FIFO, plus branch targets for the pc.
- Emits at most one registered write per cycle as a data bus and select code, ready for the demux's mux_in/sel inputs.
- Select encoding: 0x000–0x00F = reg0–reg15; 0x0FF = pc; all-ones = idle, which decodes to no register.

Parameters:
- PA_DATA, 32, data/result width.
- PA_SEL, 9, select code width, matching the demux.
- PA_DEPTH, 4, writeback FIFO entries; power of two, at least 2.
- PA_PTR, 2, log2(PA_DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_b  in  1  asynchronous reset, active-high (rst_b=1 resets).
- alu_valid  in  1  ALU result present.
- alu_rd  in  4  ALU destination register.
- alu_data  in  PA_DATA  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is high.
- ld_valid  in  1  load result present.
- ld_rd  in  4  load destination register.
- ld_data  in  PA_DATA  load data.
- ld_ready  out  1  load result accepted this cycle when ld_valid is high.
- br_valid  in  1  taken branch this cycle.
- br_target  in  PA_DATA  new pc value.
- wb_valid  out  1  wb_sel/wb_data carry a real write.
- wb_sel  out  PA_SEL  select code to demux.
- wb_data  out  PA_DATA  write data to demux.
- fifo_count  out  PA_PTR+1  current FIFO occupancy.

Behaviour:
- Reset (async, while rst_b=1):
  - wr_ptr=0, rd_ptr=0, fifo_count=0.
  - wb_valid=0, wb_sel={PA_SEL{1'b1}}, wb_data=0.
  - Queued entries are discarded. Reset mid-drain loses all pending writes; there is no partial output.
- FIFO entry = {rd[3:0], data}. Pointers wrap modulo PA_DEPTH.
- Ready logic (combinational from registered fifo_count; a same-cycle pop does not create space):
  - space = PA_DEPTH - fifo_count.
  - alu_ready = (space >= 1).
  - ld_ready = (space >= 1 + (alu_valid & alu_ready)).
- Push:
  - A push occurs when valid & ready.
  - If both push in the same cycle, the ALU entry is written at wr_ptr and the load entry at wr_ptr+1; wr_ptr advances by 2.
  - With the same rd from both, both writes are issued in that order, so the load value lands last.
- Output stage, registered, priority order each cycle:
  1. br_valid=1: wb_valid=1, wb_sel=0x0FF, wb_data=br_target. The FIFO is not popped.
  2. Else fifo_count>0: pop the head. wb_valid=1, wb_sel={(PA_SEL-4)'b0, rd}, wb_data=data. rd_ptr advances by 1.
  3. Else: wb_valid=0, wb_sel=all-ones, wb_data=0.
- Latency:
  - Branch: br_valid sampled at edge k appears on the outputs after edge k.
  - Register result: pushed at edge k onto an empty FIFO appears after edge k+1, absent a branch at k+1.
- Count update: fifo_count_next = fifo_count + pushes(0..2) − pop(0/1). Never exceeds PA_DEPTH and never underflows.
- Full (fifo_count=PA_DEPTH): both readies are low and inputs are held by the producers. A pop that cycle still occurs, so ready rises the following cycle.
- Empty with no branch: idle code every cycle.
- Consecutive branches: each is issued and drain stalls for the whole burst. The FIFO retains its order.
- Every cycle drives exactly one select code, so downstream sees at most one write per cycle.

Test Plan:
- Reset: assert rst_b mid-cycle with 3 entries queued → outputs go immediately (asynchronously) to wb_valid=0, wb_sel=0x1FF, wb_data=0, fifo_count=0. After release with no inputs, the idle code holds.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at edge 0 → after edge 1: wb_valid=1, wb_sel=0x005, wb_data=0xDEADBEEF. After edge 2: idle.
- Dual push ordering: alu (rd=3, 0x11) and ld (rd=3, 0x22) in the same cycle from empty → outputs sel 0x003/0x11, then sel 0x003/0x22 on consecutive cycles. fifo_count goes 2, 1, 0.
- Branch preemption: 2 entries queued, then br_valid=1, br_target=0x100 for 2 cycles → two outputs of sel 0x0FF/0x100 first, then the queued entries in order. fifo_count is unchanged during the branches.
- Full/backpressure: hold br_valid=1 while pushing 4 ALU writes → fifo_count=4, alu_ready=0, ld_ready=0. A 5th alu_valid is not accepted. Drop br_valid → the pop frees space and alu_ready=1 on the next cycle.
- ld_ready gating: fifo_count=3 with alu_valid=1 and ld_valid=1 → alu_ready=1, ld_ready=0. Only the ALU entry is pushed and fifo_count=4.
